// File: rtl/trace_commit_sequencer.sv
// -----------------------------------------------------------------------------
// trace_commit_sequencer
//
// Purpose: collects up to two committed instructions per cycle from a
// dual-commit core, stamps them with a free-running 32-bit timestamp and
// buffers them in a small FIFO for a trace sink. Records that do not fit
// are dropped, which sets a sticky overflow flag and (optionally) bumps a
// saturating drop counter.
//
// Optional feature: define TRACE_SEQ_DROP_CNT_EN to build the drop counter.
// Without it, no counter register exists and drop_cnt_o is tied to 0;
// overflow_o works the same either way.
//
// Ports:
//   clk_i           clock, all logic on rising edge
//   rst_ni          asynchronous active-low reset
//   trace_en_i      accept new commits when high
//   flush_i         discard all buffered records (and same-cycle enq/deq)
//   clear_i         clear overflow flag and drop counter
//   commit_valid_i  per-port commit valid, port 0 is the older one
//   commit_pc_i     committed PC per port
//   commit_instr_i  instruction word per port
//   commit_ex_i     exception flag per port
//   priv_lvl_i      current privilege level (shared)
//   rec_valid_o     head record valid
//   rec_ready_i     sink accepts head record
//   rec_o           {ts[31:0], priv[1:0], ex, instr[31:0], pc[63:0]}
//   overflow_o      sticky, set on any drop
//   drop_cnt_o      saturating count of dropped records
// -----------------------------------------------------------------------------
module trace_commit_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  trace_en_i,
    input  logic                  flush_i,
    input  logic                  clear_i,
    input  logic [1:0]            commit_valid_i,
    input  logic [1:0][63:0]      commit_pc_i,
    input  logic [1:0][31:0]      commit_instr_i,
    input  logic [1:0]            commit_ex_i,
    input  logic [1:0]            priv_lvl_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [130:0]          rec_o,
    output logic                  overflow_o,
    output logic [CNT_W-1:0]      drop_cnt_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] DEPTH_L = FILL_W'(DEPTH);

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [FILL_W-1:0] r_count;
    logic [31:0]       r_ts;
    logic              r_overflow;
    logic [130:0]      r_mem [DEPTH];

    logic [130:0]      w_rec [2];
    logic [130:0]      w_first;
    logic [PTR_W-1:0]  w_wr_ptr_p1;
    logic [FILL_W-1:0] w_free;
    logic [1:0]        w_nvalid;
    logic [1:0]        w_acc;
    logic [1:0]        w_drops;
    logic              w_deq;

    // Per-port record, stamped with the timestamp of the commit cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rec
        assign w_rec[gi] = {r_ts, priv_lvl_i, commit_ex_i[gi],
                            commit_instr_i[gi], commit_pc_i[gi]};
    end

    // The oldest valid port always lands in the first free slot; the second
    // slot is only used when both ports are accepted.
    assign w_first     = commit_valid_i[0] ? w_rec[0] : w_rec[1];
    assign w_wr_ptr_p1 = r_wr_ptr + 1'b1;
    assign w_deq       = (r_count != '0) && rec_ready_i;

    // Free space is taken from the start-of-cycle count, so a dequeue in the
    // same cycle never makes room for an incoming commit.
    always_comb begin
        w_nvalid = 2'd0;
        w_acc    = 2'd0;
        w_drops  = 2'd0;
        w_free   = DEPTH_L - r_count;
        if (trace_en_i) begin
            w_nvalid = {1'b0, commit_valid_i[0]} + {1'b0, commit_valid_i[1]};
        end
        if (w_free >= FILL_W'(w_nvalid)) begin
            w_acc = w_nvalid;
        end else begin
            w_acc = w_free[1:0];    // free is 0 or 1 here
        end
        w_drops = w_nvalid - w_acc;
    end

    // Storage has no reset: contents are only visible while count != 0.
    always_ff @(posedge clk_i) begin
        if (!flush_i && (w_acc != 2'd0)) begin
            r_mem[r_wr_ptr] <= w_first;
        end
        if (!flush_i && (w_acc == 2'd2)) begin
            r_mem[w_wr_ptr_p1] <= w_rec[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ts     <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq);
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_acc);
                r_count  <= r_count + FILL_W'(w_acc) - FILL_W'(w_deq);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end else if (w_drops != 2'd0) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef TRACE_SEQ_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W:0]   w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_drops);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_drop_cnt <= '0;
        end else if (w_drops != 2'd0) begin
            // Saturate at all-ones instead of wrapping.
            r_drop_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

    assign rec_valid_o = (r_count != '0);
    assign rec_o       = rec_valid_o ? r_mem[r_rd_ptr] : '0;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_trace_commit_sequencer.sv
module tb_trace_commit_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 trace_en;
    logic                 flush;
    logic                 clear;
    logic [1:0]           commit_valid;
    logic [1:0][63:0]     commit_pc;
    logic [1:0][31:0]     commit_instr;
    logic [1:0]           commit_ex;
    logic [1:0]           priv;
    logic                 rec_valid_o;
    logic                 rec_ready;
    logic [130:0]         rec_o;
    logic                 overflow_o;
    logic [CNT_W-1:0]     drop_cnt_o;

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference state
    logic [130:0]     q[$];
    logic [31:0]      m_ts;
    logic             m_ovf;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    trace_commit_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .trace_en_i     (trace_en),
        .flush_i        (flush),
        .clear_i        (clear),
        .commit_valid_i (commit_valid),
        .commit_pc_i    (commit_pc),
        .commit_instr_i (commit_instr),
        .commit_ex_i    (commit_ex),
        .priv_lvl_i     (priv),
        .rec_valid_o    (rec_valid_o),
        .rec_ready_i    (rec_ready),
        .rec_o          (rec_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    task automatic idle_inputs();
        trace_en     = 1'b1;
        flush        = 1'b0;
        clear        = 1'b0;
        commit_valid = 2'b00;
        commit_ex    = 2'b00;
        priv         = 2'd3;
    endtask

    // One clock cycle: compare DUT outputs with the scoreboard head, then
    // advance the reference model with the inputs currently driven.
    task automatic step();
        int free;
        int nrec;
        int drops;
        logic deq;
        logic [130:0] recs [2];
        longint sum;
        @(negedge clk);
        checks++;
        if (rec_valid_o !== (q.size() != 0)) begin
            errors++;
            $display("FAIL sb_valid: got %b expected %b", rec_valid_o, (q.size() != 0));
        end
        if (q.size() != 0) begin
            checks++;
            if (rec_o !== q[0]) begin
                errors++;
                $display("FAIL sb_rec: got %h expected %h", rec_o, q[0]);
            end
        end
        checks++;
        if (overflow_o !== m_ovf) begin
            errors++;
            $display("FAIL sb_overflow: got %b expected %b", overflow_o, m_ovf);
        end
        checks++;
        if (drop_cnt_o !== m_cnt) begin
            errors++;
            $display("FAIL sb_drop_cnt: got %h expected %h", drop_cnt_o, m_cnt);
        end

        free  = DEPTH - q.size();
        deq   = (q.size() != 0) && rec_ready;
        nrec  = 0;
        drops = 0;
        if (trace_en) begin
            for (int p = 0; p < 2; p++) begin
                if (commit_valid[p]) begin
                    if (nrec < free) begin
                        recs[nrec] = {m_ts, priv, commit_ex[p], commit_instr[p], commit_pc[p]};
                        nrec++;
                    end else begin
                        drops++;
                    end
                end
            end
        end
        if (flush) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            for (int i = 0; i < nrec; i++) q.push_back(recs[i]);
        end
        if (clear) begin
            m_ovf = 1'b0;
            m_cnt = '0;
        end else if (drops > 0) begin
            m_ovf = 1'b1;
`ifdef TRACE_SEQ_DROP_CNT_EN
            sum = longint'(m_cnt) + longint'(drops);
            if (sum > ((longint'(1) << CNT_W) - 1)) m_cnt = '1;
            else m_cnt = CNT_W'(sum);
`else
            sum = 0;
`endif
        end
        m_ts = m_ts + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1);
        commit_valid    = v;
        commit_pc[0]    = pc0;
        commit_pc[1]    = pc1;
        commit_instr[0] = pc0[31:0] ^ 32'h1357_9bdf;
        commit_instr[1] = pc1[31:0] ^ 32'h2468_ace0;
    endtask

    task automatic drain();
        idle_inputs();
        rec_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_commit(2'b00, 64'h0, 64'h0);
        rec_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rec_valid_o); end
        checks++;
        if (rec_o !== '0) begin errors++; $display("FAIL reset_rec: got %h expected 0", rec_o); end
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
        checks++;
        if (drop_cnt_o !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 0", drop_cnt_o); end
        q.delete();
        m_ts  = 32'd0;
        m_ovf = 1'b0;
        m_cnt = '0;
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_dual_commit();
        logic [31:0] ts0;
        rec_ready = 1'b1;
        set_commit(2'b11, 64'h8000_0000, 64'h8000_0004);
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++;
        if (rec_valid_o !== 1'b1 || rec_o[63:0] !== 64'h8000_0000) begin
            errors++;
            $display("FAIL dual_first: got valid=%b pc=%h expected valid=1 pc=80000000", rec_valid_o, rec_o[63:0]);
        end
        ts0 = rec_o[130:99];
        step();
        checks++;
        if (rec_valid_o !== 1'b1 || rec_o[63:0] !== 64'h8000_0004) begin
            errors++;
            $display("FAIL dual_second: got valid=%b pc=%h expected valid=1 pc=80000004", rec_valid_o, rec_o[63:0]);
        end
        checks++;
        if (rec_o[130:99] !== ts0) begin
            errors++;
            $display("FAIL dual_ts: got %h expected %h", rec_o[130:99], ts0);
        end
        step();
        step();
        $display("test_dual_commit done");
    endtask

    task automatic test_port1_only();
        rec_ready = 1'b0;
        set_commit(2'b10, 64'h1000, 64'h2000);
        commit_ex = 2'b10;
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        commit_ex = 2'b00;
        checks++;
        if (rec_o[63:0] !== 64'h2000 || rec_o[96] !== 1'b1) begin
            errors++;
            $display("FAIL port1_only: got pc=%h ex=%b expected pc=2000 ex=1", rec_o[63:0], rec_o[96]);
        end
        step();
        drain();
        $display("test_port1_only done");
    endtask

    task automatic test_overflow();
        logic [CNT_W-1:0] exp_cnt;
`ifdef TRACE_SEQ_DROP_CNT_EN
        exp_cnt = CNT_W'(2);
`else
        exp_cnt = '0;
`endif
        do_clear();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_commit(2'b11, 64'h100 + 64'(16 * i), 64'h104 + 64'(16 * i));
            step();
        end
        set_commit(2'b00, 64'h0, 64'h0);
        checks++;
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b expected 1", overflow_o); end
        checks++;
        if (drop_cnt_o !== exp_cnt) begin errors++; $display("FAIL overflow_cnt: got %h expected %h", drop_cnt_o, exp_cnt); end
        checks++;
        if (q.size() != 4 || rec_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_depth: got valid=%b entries=%0d expected valid=1 entries=4", rec_valid_o, q.size());
        end
        drain();
        $display("test_overflow done");
    endtask

    task automatic test_full_deq_drop();
        logic [CNT_W-1:0] exp_cnt;
`ifdef TRACE_SEQ_DROP_CNT_EN
        exp_cnt = CNT_W'(1);
`else
        exp_cnt = '0;
`endif
        do_clear();
        rec_ready = 1'b0;
        set_commit(2'b11, 64'h300, 64'h304);
        step();
        set_commit(2'b11, 64'h308, 64'h30c);
        step();
        rec_ready = 1'b1;
        set_commit(2'b01, 64'h310, 64'h0);
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        checks++;
        if (drop_cnt_o !== exp_cnt || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL full_deq_drop: got cnt=%h ovf=%b expected cnt=%h ovf=1", drop_cnt_o, overflow_o, exp_cnt);
        end
        drain();
        $display("test_full_deq_drop done");
    endtask

    task automatic test_trace_disable();
        do_clear();
        rec_ready = 1'b0;
        set_commit(2'b11, 64'h400, 64'h404);
        step();
        step();
        trace_en = 1'b0;
        rec_ready = 1'b1;
        set_commit(2'b11, 64'h500, 64'h504);
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (rec_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL trace_disable: got valid=%b ovf=%b expected valid=0 ovf=0", rec_valid_o, overflow_o);
        end
        drain();
        $display("test_trace_disable done");
    endtask

    task automatic test_flush();
        rec_ready = 1'b0;
        set_commit(2'b11, 64'h600, 64'h604);
        step();
        set_commit(2'b01, 64'h608, 64'h0);
        step();
        flush = 1'b1;
        set_commit(2'b01, 64'h60c, 64'h0);
        step();
        flush = 1'b0;
        set_commit(2'b00, 64'h0, 64'h0);
        checks++;
        if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", rec_valid_o); end
        step();
        checks++;
        if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", rec_valid_o); end
        $display("test_flush done");
    endtask

    task automatic test_clear_priority();
        rec_ready = 1'b0;
        set_commit(2'b11, 64'h700, 64'h704);
        step();
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        set_commit(2'b00, 64'h0, 64'h0);
        checks++;
        if (overflow_o !== 1'b0 || drop_cnt_o !== '0) begin
            errors++;
            $display("FAIL clear_priority: got ovf=%b cnt=%h expected ovf=0 cnt=0", overflow_o, drop_cnt_o);
        end
        drain();
        $display("test_clear_priority done");
    endtask

`ifdef TRACE_SEQ_DROP_CNT_EN
    task automatic test_saturate();
        do_clear();
        rec_ready = 1'b0;
        set_commit(2'b11, 64'h800, 64'h804);
        step();
        step();
        for (int i = 0; i < 32767; i++) step();
        checks++;
        if (drop_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", drop_cnt_o); end
        step();
        checks++;
        if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_max: got %h expected ffff", drop_cnt_o); end
        step();
        checks++;
        if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", drop_cnt_o); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (drop_cnt_o !== 16'h0000) begin errors++; $display("FAIL sat_clear: got %h expected 0", drop_cnt_o); end
        drain();
        $display("test_saturate done");
    endtask
`endif

    task automatic test_reset_midop();
        rec_ready = 1'b0;
        set_commit(2'b11, 64'h900, 64'h904);
        step();
        set_commit(2'b11, 64'h908, 64'h90c);
        step();
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rec_valid_o !== 1'b0 || rec_o !== '0) begin
            errors++;
            $display("FAIL midop_reset: got valid=%b rec=%h expected valid=0 rec=0", rec_valid_o, rec_o);
        end
        checks++;
        if (overflow_o !== 1'b0 || drop_cnt_o !== '0) begin
            errors++;
            $display("FAIL midop_reset_flags: got ovf=%b cnt=%h expected 0/0", overflow_o, drop_cnt_o);
        end
        q.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ts = 32'd0;
        rec_ready = 1'b1;
        step();
        step();
        $display("test_reset_midop done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            commit_valid    = 2'($urandom_range(0, 3));
            commit_pc[0]    = {$urandom, $urandom};
            commit_pc[1]    = {$urandom, $urandom};
            commit_instr[0] = $urandom;
            commit_instr[1] = $urandom;
            commit_ex       = 2'($urandom_range(0, 3));
            priv            = 2'($urandom_range(0, 3));
            rec_ready       = ($urandom_range(0, 2) != 0);
            trace_en        = ($urandom_range(0, 7) != 0);
            flush           = ($urandom_range(0, 19) == 0);
            clear           = ($urandom_range(0, 29) == 0);
            step();
        end
        drain();
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b0;
        m_ts  = 32'd0;
        m_ovf = 1'b0;
        m_cnt = '0;
        idle_inputs();
        set_commit(2'b00, 64'h0, 64'h0);
        rec_ready = 1'b0;
        test_reset();
        test_dual_commit();
        test_port1_only();
        test_overflow();
        test_full_deq_drop();
        test_trace_disable();
        test_flush();
        test_clear_priority();
`ifdef TRACE_SEQ_DROP_CNT_EN
        test_saturate();
`endif
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_commit_sequencer.md
TRACE_COMMIT_SEQUENCER -- requirements
Module: trace_commit_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, drop counter width.
REQ-003 SHALL have clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have trace_en_i, input, 1, accept new commits when high.
REQ-006 SHALL have flush_i, input, 1, discard all buffered records.
REQ-007 SHALL have clear_i, input, 1, clear overflow flag and drop counter.
REQ-008 SHALL have commit_valid_i, input, 2, per-port commit acknowledge; port 0 is older.
REQ-009 SHALL have commit_pc_i, input, 2x64, committed PC per port.
REQ-010 SHALL have commit_instr_i, input, 2x32, instruction word per port.
REQ-011 SHALL have commit_ex_i, input, 2, exception flag per port.
REQ-012 SHALL have priv_lvl_i, input, 2, current privilege level, shared by both ports.
REQ-013 SHALL have rec_valid_o, output, 1, head record valid.
REQ-014 SHALL have rec_ready_i, input, 1, sink accepts head record.
REQ-015 SHALL have rec_o, output, 131, {ts[31:0], priv[1:0], ex, instr[31:0], pc[63:0]}.
REQ-016 SHALL have overflow_o, output, 1, sticky flag set on any drop.
REQ-017 SHALL have drop_cnt_o, output, CNT_W, count of dropped records.

Function
REQ-018 SHALL keep a free-running 32-bit timestamp that increments every cycle and wraps from 0xFFFFFFFF to 0; each record captures its value in the commit cycle.
REQ-019 SHALL enqueue valid ports in order: port 0 before port 1; port 1 alone when only commit_valid_i[1] is set.
REQ-020 SHALL compute free = DEPTH - count at the start of the cycle; a same-cycle dequeue SHALL NOT add space.
REQ-021 SHALL, with free=1 and both ports valid, enqueue port 0 and drop port 1; with free=0, drop every valid port.
REQ-022 SHALL raise rec_valid_o when count != 0; rec_o SHALL be the head entry, registered, so a commit appears on rec_o 1 cycle later at the earliest.
REQ-023 SHALL dequeue the head when rec_valid_o && rec_ready_i; rec_o SHALL stay stable while rec_valid_o && !rec_ready_i.
REQ-024 SHALL ignore commits while trace_en_i is low; these SHALL NOT count as drops, and the FIFO SHALL continue to drain.
REQ-025 SHALL, on flush_i, empty the FIFO next cycle and also discard the same-cycle enqueue and dequeue; rec_valid_o SHALL be low in the following cycle.
REQ-026 SHALL add the number of drops per cycle (0..2) to the drop counter, saturating at all-ones.
REQ-027 SHALL give clear_i priority over same-cycle drops: the counter goes to 0 and overflow_o goes low.
REQ-028 SHALL wrap read/write pointers modulo DEPTH and distinguish full from empty with an explicit count.

Reset
REQ-029 SHALL, on rst_ni low, asynchronously set: count, pointers and timestamp to 0; rec_valid_o 0; rec_o 0; overflow_o 0; drop_cnt_o 0.
REQ-030 SHALL, when reset asserts mid-operation, lose all buffered records with no partial output.

Configuration
REQ-031 SHALL use macro TRACE_SEQ_DROP_CNT_EN: defined -> drop counter per REQ-026/027; undefined -> no counter register and drop_cnt_o tied to 0, with overflow_o unaffected.

Verification
REQ-032 Both ports valid in one cycle, pc 0x80000000/0x80000004, ready=1 -> two records in consecutive cycles, port 0 first, ts differing by 0.
REQ-033 DEPTH=4, ready=0, 3 cycles of dual commits -> 4 entries buffered, 2 dropped, overflow_o=1, drop_cnt_o=2.
REQ-034 FIFO full, ready=1 and port 0 valid in the same cycle -> port 0 dropped, drop_cnt_o +1.
REQ-035 Counter at 0xFFFE, dual drop -> 0xFFFF; with clear_i in the same cycle -> 0.
REQ-036 3 entries buffered, flush_i plus a port-0 commit -> rec_valid_o=0 next cycle, count 0.
REQ-037 Macro undefined, overflow forced -> overflow_o=1 and drop_cnt_o=0.
